// File: rtl/scara_pkg.sv
// scara_pkg: shared types and constants for the SCARA stepper datapath
package scara_pkg;
   localparam int STEP_W = 8;
   typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} sched_state_t;
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter; expire is high on the last cycle of a loaded interval
module pulse_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
   assign expire = cnt_q == W'(1);
endmodule

// File: rtl/stepper_pulse_scheduler.sv
// stepper_pulse_scheduler: turns a two-axis step command into coordinated STEP/DIR
// pulse trains with Bresenham interleaving, and tracks signed per-axis positions
module stepper_pulse_scheduler
   import scara_pkg::*;
#(
   parameter int DIR_SETUP   = 20,
   parameter int PULSE_HIGH  = 50,
   parameter int STEP_PERIOD = 2000,
   parameter int POS_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [STEP_W-1:0] steps1,
   input  logic [STEP_W-1:0] steps2,
   input  logic              dir1,
   input  logic              dir2,
   input  logic              dataReady,
   input  logic              abort,
   output logic              stepperReady,
   output logic              step1Out,
   output logic              step2Out,
   output logic              dir1Out,
   output logic              dir2Out,
   output logic              moveDone,
   output logic [POS_W-1:0]  pos1,
   output logic [POS_W-1:0]  pos2
);
   localparam int TW = $clog2(DIR_SETUP + STEP_PERIOD + 1);
   sched_state_t state_q, state_d;
   logic dr_prev_q, dir1_q, dir1_d, dir2_q, dir2_d, step1_q, step1_d, step2_q, step2_d;
   logic ready_q, ready_d, done_q, done_d, maj1_q, maj1_d;
   logic [POS_W-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
   logic [STEP_W-1:0] major_q, major_d, minor_q, minor_d, slot_q, slot_d, mx, mn;
   logic [STEP_W:0] err_q, err_d, sum;
   logic accept, hit, go, t_load, t_exp;
   logic [TW-1:0] t_val;

   pulse_timer #(.W(TW)) u_timer (
      .clk(clk), .reset(reset), .load(t_load), .load_val(t_val), .expire(t_exp)
   );

   always_comb begin
      accept = state_q == IDLE && dataReady && !dr_prev_q;
      mx = steps1 >= steps2 ? steps1 : steps2;
      mn = steps1 >= steps2 ? steps2 : steps1;
      sum = err_q + {1'b0, minor_q};
      hit = sum >= {1'b0, major_q};
      state_d = state_q;
      dir1_d = dir1_q;
      dir2_d = dir2_q;
      step1_d = step1_q;
      step2_d = step2_q;
      done_d = 1'b0;
      maj1_d = maj1_q;
      major_d = major_q;
      minor_d = minor_q;
      slot_d = slot_q;
      err_d = err_q;
      pos1_d = pos1_q;
      pos2_d = pos2_q;
      t_load = 1'b0;
      t_val = '0;
      go = 1'b0;
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         step1_d = 1'b0;
         step2_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               dir1_d = dir1;
               dir2_d = dir2;
               major_d = mx;
               minor_d = mn;
               maj1_d = steps1 >= steps2;
               err_d = '0;
               slot_d = '0;
               done_d = mx == '0;
               state_d = mx == '0 ? IDLE : SETUP;
               t_load = 1'b1;
               t_val = TW'(DIR_SETUP);
            end
            SETUP: go = t_exp;
            PULSE: if (t_exp) begin
               state_d = GAP;
               step1_d = 1'b0;
               step2_d = 1'b0;
               t_load = 1'b1;
               t_val = TW'(STEP_PERIOD - PULSE_HIGH);
            end
            GAP: if (t_exp) begin
               done_d = slot_q == major_q;
               state_d = slot_q == major_q ? IDLE : state_q;
               go = slot_q != major_q;
            end
            default: state_d = IDLE;
         endcase
      end
      // slot start: the major axis always steps, the minor one only on accumulator overflow
      if (go) begin
         state_d = PULSE;
         t_load = 1'b1;
         t_val = TW'(PULSE_HIGH);
         slot_d = slot_q + STEP_W'(1);
         err_d = hit ? sum - {1'b0, major_q} : sum;
         step1_d = maj1_q | hit;
         step2_d = !maj1_q | hit;
         pos1_d = step1_d ? pos1_q + (dir1_q ? POS_W'(1) : '1) : pos1_q;
         pos2_d = step2_d ? pos2_q + (dir2_q ? POS_W'(1) : '1) : pos2_q;
      end
      ready_d = state_d == IDLE && !(accept && mx == '0);
   end

   always_ff @(posedge clk) begin
      dr_prev_q <= dataReady;
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         {dir1_q, dir2_q, step1_q, step2_q, done_q, maj1_q} <= '0;
         {major_q, minor_q, slot_q, err_q} <= '0;
         pos1_q <= '0;
         pos2_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         {dir1_q, dir2_q, step1_q, step2_q, done_q, maj1_q} <= {dir1_d, dir2_d, step1_d, step2_d, done_d, maj1_d};
         {major_q, minor_q, slot_q, err_q} <= {major_d, minor_d, slot_d, err_d};
         pos1_q <= pos1_d;
         pos2_q <= pos2_d;
      end
   end

   assign stepperReady = ready_q;
   assign step1Out = step1_q;
   assign step2Out = step2_q;
   assign dir1Out = dir1_q;
   assign dir2Out = dir2_q;
   assign moveDone = done_q;
   assign pos1 = pos1_q;
   assign pos2 = pos2_q;
endmodule
